// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte sources
// Grants one requester per frame, launches it and tracks tx_busy until the frame ends or times out.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LAUNCH_TMO = 64,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W     = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active,
  output logic                          done,
  output logic                          tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [CNT_W-1:0]      r_tmo_cnt;
  logic                  r_tmo_err;

  logic [NUM_REQ-1:0]    w_elig;
  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_grant;
  logic                  w_tmo_hit;
  logic                  w_start;
  logic                  w_active;
  logic                  w_done;

  function automatic logic [ID_W-1:0] f_wrap(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  assign w_elig = req_valid & req_en;

  // Search starts at the round-robin pointer and wraps around the requester ring.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_elig[f_wrap(int'(r_rr_ptr) + k)]) begin
        w_found  = 1'b1;
        w_winner = f_wrap(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_sel_data = req_data[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_tmo_hit   = 1'b0;
    w_start     = 1'b0;
    w_active    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A busy transmitter in IDLE belongs to someone else; hold off granting.
        if (reset_n && w_found && !tx_busy) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_start  = 1'b1;
        w_active = 1'b1;
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmo_cnt == CNT_W'(LAUNCH_TMO - 1)) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        w_active = 1'b1;
        if (!tx_busy) begin
          w_done      = reset_n;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_tmo_cnt  <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_tmo_err <= w_tmo_hit;
      if (w_grant) begin
        r_tx_data  <= w_sel_data;
        r_grant_id <= w_winner;
        r_rr_ptr   <= f_wrap(int'(w_winner) + 1);
        r_tmo_cnt  <= '0;
      end else if (r_state == S_LAUNCH && !tx_busy && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign req_ready = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
  assign tx_start  = w_start;
  assign active    = w_active;
  assign done      = w_done;
  assign tmo_err   = r_tmo_err;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Frame-level reference model plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TMO  = 16;
  localparam int BLEN = 160;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_en;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          active;
  logic          done;
  logic          tmo_err;

  logic mbusy = 1'b0;
  int   bcnt  = 0;
  logic dead  = 1'b0;
  logic force_busy = 1'b0;

  int errors = 0;
  int checks = 0;

  int ready_cnt = 0, start_cnt = 0, done_cnt = 0, tmo_cnt = 0, overlap_cnt = 0;
  int glog[$];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LAUNCH_TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_en(req_en), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .done(done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = mbusy | force_busy;

  // Transmitter stand-in: registers start, then stays busy for BLEN cycles.
  always @(posedge clk) begin
    if (dead) begin
      mbusy <= 1'b0;
    end else if (mbusy) begin
      if (bcnt == 0) mbusy <= 1'b0;
      else           bcnt  <= bcnt - 1;
    end else if (tx_start) begin
      mbusy <= 1'b1;
      bcnt  <= BLEN - 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Frame-level model: owned/launched flags, launch age, and last-grant record.
  initial begin : model
    logic       m_own, m_launched, m_tmo;
    int         m_age, m_rr, m_gid, m_data;
    logic [N-1:0] e;
    logic       rn, b;
    int         win, e_ready;
    m_own = 0; m_launched = 0; m_tmo = 0; m_age = 0; m_rr = 0; m_gid = 0; m_data = 0;
    forever begin
      @(negedge clk);
      rn = reset_n; b = tx_busy; e = req_valid & req_en;
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && e[(m_rr + k) % N]) win = (m_rr + k) % N;
      end
      e_ready = (rn && !m_own && !b && win >= 0) ? (1 << win) : 0;
      chk("m_req_ready", int'(req_ready), e_ready);
      chk("m_tx_start", int'(tx_start), int'(m_own && !m_launched));
      chk("m_active", int'(active), int'(m_own));
      chk("m_done", int'(done), int'(rn && m_own && m_launched && !b));
      chk("m_tmo_err", int'(tmo_err), int'(m_tmo));
      chk("m_tx_data", int'(tx_data), m_data);
      chk("m_grant_id", int'(grant_id), m_gid);
      if (rn) begin
        ready_cnt += $countones(req_ready);
        start_cnt += int'(tx_start);
        done_cnt  += int'(done);
        tmo_cnt   += int'(tmo_err);
        if (done && (|req_ready)) overlap_cnt++;
        for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      end
      if (!rn) begin
        m_own = 0; m_launched = 0; m_tmo = 0; m_age = 0; m_rr = 0; m_gid = 0; m_data = 0;
      end else begin
        m_tmo = 0;
        if (!m_own) begin
          if (e_ready != 0) begin
            m_own = 1; m_launched = 0; m_age = 0;
            m_data = int'(req_data[win*DW +: DW]);
            m_gid = win; m_rr = (win + 1) % N;
          end
        end else if (!m_launched) begin
          if (b) m_launched = 1;
          else if (m_age == TMO - 1) begin m_own = 0; m_tmo = 1; end
          else m_age++;
        end else if (!b) begin
          m_own = 0;
        end
      end
    end
  end

  task automatic wait_ready(input int budget, output logic [N-1:0] rv);
    rv = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (|req_ready) begin rv = req_ready; break; end
    end
    if (rv == '0) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_tmo(input int budget);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (tmo_err) begin seen = 1'b1; break; end
    end
    if (!seen) chk("tmo_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [N-1:0] rv;
    int s0, d0, t0, r0, g0;
    int exp2[5] = '{0, 1, 2, 3, 0};
    int exp3[4] = '{2, 3, 0, 1};
    reset_n = 1'b0; req_en = '1; req_valid = '0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // single frame from requester 0
    req_data[0 +: 8] = 8'hA5;
    s0 = start_cnt; d0 = done_cnt; r0 = ready_cnt;
    req_valid = 4'b0001;
    wait_ready(10, rv);
    chk("t1_ready_vec", int'(rv), 1);
    req_valid = '0;
    wait_done(400);
    chk("t1_ready_cnt", ready_cnt - r0, 1);
    chk("t1_start_cycles", start_cnt - s0, 2);
    chk("t1_done_cnt", done_cnt - d0, 1);
    @(negedge clk);
    chk("t1_tx_data", int'(tx_data), 8'hA5);
    chk("t1_active_idle", int'(active), 0);

    // rotation over all four with valid held
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    g0 = glog.size(); r0 = ready_cnt;
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) wait_done(400);
    req_valid = '0;
    chk("t2_ready_cnt", ready_cnt - r0, 5);
    for (int i = 0; i < 5; i++) chk("t2_grant_seq", (glog.size() > g0 + i) ? glog[g0 + i] : -1, exp2[i]);
    chk("t2_overlap", overlap_cnt, 0);
    chk("t2_tx_data", int'(tx_data), 8'h11);

    // skip-ahead after grant of 2
    g0 = glog.size();
    req_valid = 4'b0100;
    wait_ready(10, rv);
    req_valid = 4'b1001;
    wait_done(400);
    wait_ready(10, rv);
    chk("t3_second", int'(rv), 4'b1000);
    req_valid = 4'b0001;
    wait_done(400);
    wait_ready(10, rv);
    req_valid = '0;
    wait_done(400);
    req_valid = 4'b1111;
    wait_ready(10, rv);
    chk("t3_rr_is_1", int'(rv), 4'b0010);
    req_valid = '0;
    wait_done(400);
    for (int i = 0; i < 4; i++) chk("t3_grant_seq", (glog.size() > g0 + i) ? glog[g0 + i] : -1, exp3[i]);

    // launch timeout with a dead transmitter
    dead = 1'b1;
    s0 = start_cnt; d0 = done_cnt; t0 = tmo_cnt;
    req_valid = 4'b0001;
    wait_ready(10, rv);
    chk("t4_first", int'(rv), 4'b0001);
    req_valid = '0;
    wait_tmo(40);
    chk("t4_start_cycles", start_cnt - s0, TMO);
    chk("t4_tmo_pulses", tmo_cnt - t0, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    dead = 1'b0;
    req_valid = 4'b0010;
    wait_ready(10, rv);
    chk("t4_next_grant", int'(rv), 4'b0010);
    req_valid = '0;
    wait_done(400);

    // reset during WAIT_DONE
    req_valid = 4'b1100;
    wait_ready(10, rv);
    chk("t5_grant2", int'(rv), 4'b0100);
    req_valid = 4'b1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_pre_active", int'(active), 1);
    chk("t5_pre_start", int'(tx_start), 0);
    @(posedge clk); #1;
    reset_n = 1'b0; req_valid = 4'b1010;
    @(posedge clk); #1;
    reset_n = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_start", int'(tx_start), 0);
    chk("t5_active", int'(active), 0);
    chk("t5_ready", int'(req_ready), 0);
    chk("t5_grant_id", int'(grant_id), 0);
    chk("t5_done", int'(done), 0);
    wait_ready(300, rv);
    chk("t5_lowest", int'(rv), 4'b0010);
    chk("t5_no_done", done_cnt - d0, 0);
    req_valid = 4'b1000;
    wait_done(400);
    wait_ready(10, rv);
    req_valid = '0;
    wait_done(400);

    // disabled requester and foreign busy
    req_en = 4'b1011;
    req_valid = 4'b0100;
    r0 = ready_cnt; s0 = start_cnt;
    repeat (20) @(posedge clk); #1;
    chk("t6_no_ready", ready_cnt - r0, 0);
    chk("t6_no_start", start_cnt - s0, 0);
    force_busy = 1'b1; req_valid = 4'b0001;
    repeat (10) @(posedge clk); #1;
    chk("t6_busy_hold", ready_cnt - r0, 0);
    force_busy = 1'b0;
    wait_ready(10, rv);
    chk("t6_grant0", int'(rv), 4'b0001);
    req_valid = '0;
    wait_done(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
